// File: rtl/dns_hdr_if.sv
// DNS header generator bus: configuration, channel requests/grants and the header stream.
`timescale 1ns/1ps
interface dns_hdr_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              cfg_en;
    logic              cfg_qr;
    logic [3:0]        cfg_opcode;
    logic [3:0]        cfg_flags;
    logic [3:0]        cfg_rcode;
    logic [15:0]       cfg_qdcount;
    logic [15:0]       cfg_ancount;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] req_ack;
    logic              m_tvalid;
    logic              m_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic [CH_W-1:0]   m_tch;
    logic [31:0]       hdr_count;

    // Generator side: drives grants, the stream and the frame counter
    modport master (
        input  cfg_en, cfg_qr, cfg_opcode, cfg_flags, cfg_rcode, cfg_qdcount, cfg_ancount,
        input  req, m_tready,
        output req_ack, m_tvalid, m_tdata, m_tlast, m_tch, hdr_count
    );

    // Requester / sink side
    modport slave (
        output cfg_en, cfg_qr, cfg_opcode, cfg_flags, cfg_rcode, cfg_qdcount, cfg_ancount,
        output req, m_tready,
        input  req_ack, m_tvalid, m_tdata, m_tlast, m_tch, hdr_count
    );
endinterface

// File: rtl/dns_hdr_gen.sv
// DNS header generator: per-channel transaction IDs, round-robin grant, 96-bit header
// serialised MSB first onto a valid/ready stream.
`timescale 1ns/1ps
module dns_hdr_gen #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_MODE = 0,
    parameter logic [15:0] ID_SEED = 16'h0001
) (
    input  logic      clk156,
    input  logic      sys_rst,
    dns_hdr_if.master bus
);
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SUM_W   = CH_W + 1;
    localparam int unsigned HDR_W   = 96;
    localparam int unsigned N_BEATS = HDR_W / DATA_W;
    localparam int unsigned BEAT_W  = 3;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // Reset ID of a channel; an LFSR must never start at zero
    function automatic logic [15:0] seed_of(input int unsigned c);
        logic [15:0] s;
        if (ID_MODE == 0) begin
            s = ID_SEED + 16'(c);
        end else begin
            s = ID_SEED ^ 16'(c);
            if (s == 16'h0000) s = 16'hACE1;
        end
        return s;
    endfunction

    // Next ID after a grant: wrapping increment or Fibonacci LFSR (taps 16,14,13,11)
    function automatic logic [15:0] id_adv(input logic [15:0] v);
        if (ID_MODE == 0) return v + 16'd1;
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [0:0]        state_q,  state_d;
    logic [BEAT_W-1:0] beat_q,   beat_d;
    logic [CH_W-1:0]   rr_q,     rr_d;
    logic [HDR_W-1:0]  shreg_q,  shreg_d;
    logic [15:0]       id_q [NUM_CH];
    logic [15:0]       id_d [NUM_CH];
    logic [NUM_CH-1:0] ack_q,    ack_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q,  tlast_d;
    logic [DATA_W-1:0] tdata_q,  tdata_d;
    logic [CH_W-1:0]   tch_q,    tch_d;
    logic [31:0]       cnt_q,    cnt_d;

    logic [NUM_CH-1:0] req_rot;
    logic [SUM_W-1:0]  gnt_sum;
    logic              gnt_found;
    logic [CH_W-1:0]   gnt_ch;
    logic [HDR_W-1:0]  hdr_new;

    // Round-robin pick: first requester at or after the pointer, wrapping
    always_comb begin
        req_rot   = NUM_CH'({bus.req, bus.req} >> rr_q);
        gnt_found = 1'b0;
        gnt_sum   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_found && req_rot[i]) begin
                gnt_found = 1'b1;
                gnt_sum   = {1'b0, rr_q} + SUM_W'(i);
            end
        end
        if (gnt_sum >= SUM_W'(NUM_CH)) gnt_sum = gnt_sum - SUM_W'(NUM_CH);
        gnt_ch = gnt_sum[CH_W-1:0];
    end

    // Header snapshot for the channel about to be granted
    assign hdr_new = {id_q[gnt_ch], bus.cfg_qr, bus.cfg_opcode, bus.cfg_flags, 3'b000,
                      bus.cfg_rcode, bus.cfg_qdcount, bus.cfg_ancount, 32'h0};

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        rr_d     = rr_q;
        shreg_d  = shreg_q;
        id_d     = id_q;
        ack_d    = '0;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        tch_d    = tch_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.cfg_en && gnt_found) begin
                    id_d[gnt_ch] = id_adv(id_q[gnt_ch]);
                    rr_d     = (gnt_sum == SUM_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
                    ack_d    = NUM_CH'(1) << gnt_ch;
                    tvalid_d = 1'b1;
                    tdata_d  = hdr_new[HDR_W-1 -: DATA_W];
                    shreg_d  = hdr_new << DATA_W;
                    tlast_d  = (LAST_BEAT == '0);
                    beat_d   = '0;
                    tch_d    = gnt_ch;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (bus.m_tready) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        cnt_d    = cnt_q + 32'd1;
                        state_d  = IDLE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        tdata_d = shreg_q[HDR_W-1 -: DATA_W];
                        shreg_d = shreg_q << DATA_W;
                        tlast_d = ((beat_q + BEAT_W'(1)) == LAST_BEAT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame in flight
    always_ff @(posedge clk156) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            rr_q     <= '0;
            shreg_q  <= '0;
            ack_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tch_q    <= '0;
            cnt_q    <= '0;
            for (int c = 0; c < NUM_CH; c++) id_q[c] <= seed_of(c);
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rr_q     <= rr_d;
            shreg_q  <= shreg_d;
            ack_q    <= ack_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            tch_q    <= tch_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
        end
    end

    assign bus.req_ack   = ack_q;
    assign bus.m_tvalid  = tvalid_q;
    assign bus.m_tlast   = tlast_q;
    assign bus.m_tdata   = tdata_q;
    assign bus.m_tch     = tch_q;
    assign bus.hdr_count = cnt_q;
endmodule
